led_pattern_sequencer: RTL
==========================

// Module: led_pattern_sequencer
// PURPOSE
// - Parametrised LED pattern engine for the MAX II boards: N LEDs, programmable step period, four run modes.
// - Internal prescaler divides the 50 MHz board clock into a step tick; a pattern state machine advances on each tick.
// - Sits between top-level pins (LEDs, mode switches, run button) and the rest of the board logic.
// - Outputs are registered.
// PARAMETERS
// - CLK_HZ    50_000_000  input clock frequency in Hz
// - STEP_MS   500         step period in ms; DIV = CLK_HZ/1000*STEP_MS (integer, >= 2)
// - NUM_LEDS  3           LED count, 1..16
// PORTS
// - clk        in   1         board clock, single clock domain
// - rst_n      in   1         asynchronous, active-low reset
// - mode       in   2         00 chase, 01 bounce, 10 blink-all, 11 off; synchronous to clk
// - run        in   1         1 = advance on ticks; 0 = freeze prescaler and pattern
// - led        out  NUM_LEDS  LED drive, active-high, bit 0 = LED1
// - step_tick  out  1         one-cycle pulse on each pattern advance
// BEHAVIOUR
// - Reset (rst_n=0, async): prescaler=0, pos=0, dir=up, blink_ph=1, mode_q=mode(current), led=0, step_tick=0.
// - Prescaler: cnt 0..DIV-1. tick = run && cnt==DIV-1; on tick cnt->0.
//   - run=1, no tick: cnt+1.
//   - run=0: cnt holds; no ticks generated.
// - step_tick is registered: high in the cycle after tick, for exactly 1 cycle.
// - led is registered from the state value after the update, so it changes in the same edge as step_tick rises.
// - Mode change: mode != mode_q at a clock edge restarts the sequence.
//   - cnt->0, pos->0, dir->up, blink_ph->1, mode_q->mode.
//   - Any tick in that same cycle is discarded; no step_tick.
// - Mode 00, chase: led = one-hot(pos). Each tick pos = (pos==NUM_LEDS-1) ? 0 : pos+1.
// - Mode 01, bounce: led = one-hot(pos), ping-pong with no repeat at the ends.
//   - Sequence for N=3: 0,1,2,1,0,1,...
//   - Direction flips when the next step would leave the range.
//   - NUM_LEDS=1: pos stays 0; step_tick still pulses.
// - Mode 10, blink-all: led = {NUM_LEDS{blink_ph}}. Each tick blink_ph toggles.
// - Mode 11, off: led = 0. Prescaler and step_tick keep running; pos, dir and blink_ph hold.
// - First edge after reset release: led loads the pattern for pos=0 (chase/bounce 0..01, blink all-ones, off 0).
// - Reset asserted mid-sequence: every register returns to its reset value immediately, without waiting for clk.
// - Widths:
//   - cnt is $clog2(DIV) bits; pos is $clog2(NUM_LEDS) bits (min 1).
//   - Compares use full width; cnt never exceeds DIV-1.
// - run deassert/reassert: resumes from the held cnt and pos; no step is lost or duplicated.
// CONFIGURATION
// - Macro LED_DIM_EN.
// - Defined:
//   - Adds input duty[3:0] and a free-running 4-bit PWM counter pwm, reset 0, incrementing every clk.
//   - Final output is led_pat & {NUM_LEDS{pwm < duty}}.
//   - duty=0: always dark. duty=15: on for 15 of 16 cycles.
//   - Gating is registered, so it adds no extra latency vs. undimmed led.
// - Undefined: no duty port, no PWM counter; led = led_pat.
// TESTING
// - Bench params: CLK_HZ=1000, STEP_MS=4 (DIV=4), NUM_LEDS=3; run=1 unless stated.
// - Reset then chase: led=000 during reset; 001 after the first edge.
//   - step_tick every 4 cycles; led 001->010->100->001.
// - Bounce: led 001,010,100,010,001,010 on consecutive ticks; step_tick period 4.
// - Blink-all: led 111 after reset, then 000, 111, 000 on successive ticks.
// - Mode change mid-period (chase at led=100, cnt=2; switch to bounce):
//   - Next edge gives led=001, cnt=0.
//   - Next step_tick is 4 cycles later, led=010.
// - Pause: drop run at cnt=1 for 10 cycles -> led and cnt frozen, no step_tick.
//   - After re-assert, the tick arrives 3 cycles later.
// - Async reset: assert rst_n=0 between clock edges while led=100 -> led=000 and step_tick=0 immediately.
//   - With LED_DIM_EN and duty=4: led high 4 of every 16 cycles during chase.

Source files
------------

// File: rtl/led_pattern_sequencer.sv
// LED pattern engine: prescaled step tick driving chase, bounce, blink-all and off patterns.
// Optional macro LED_DIM_EN adds a duty input and 4-bit PWM dimming of the LED outputs.
module led_pattern_sequencer #(
    parameter int CLK_HZ   = 50_000_000,
    parameter int STEP_MS  = 500,
    parameter int NUM_LEDS = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          mode,
    input  logic                run,
`ifdef LED_DIM_EN
    input  logic [3:0]          duty,
`endif
    output logic [NUM_LEDS-1:0] led,
    output logic                step_tick
);

    localparam int DIV   = CLK_HZ / 1000 * STEP_MS;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int POS_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(NUM_LEDS - 1);

    typedef enum logic [1:0] {
        MODE_CHASE  = 2'b00,
        MODE_BOUNCE = 2'b01,
        MODE_BLINK  = 2'b10,
        MODE_OFF    = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    dir_e                dir_q, dir_d;
    logic                ph_q, ph_d;
    mode_e               mode_q, mode_d;
    logic [NUM_LEDS-1:0] led_q, led_d, pat_s;
    logic                tick_q, tick_d;
    logic                tick_s;
    logic                mode_chg_s;

    function automatic logic [NUM_LEDS-1:0] pattern_f(input mode_e m, input logic [POS_W-1:0] p,
                                                       input logic ph);
        logic [NUM_LEDS-1:0] v;
        v = {NUM_LEDS{1'b0}};
        case (m)
            MODE_CHASE, MODE_BOUNCE: v = NUM_LEDS'(1) << p;
            MODE_BLINK:              v = {NUM_LEDS{ph}};
            default:                 v = {NUM_LEDS{1'b0}};
        endcase
        return v;
    endfunction

    assign mode_chg_s = (mode_e'(mode) != mode_q);
    assign tick_s     = run && (cnt_q == CNT_MAX);

    // Next-state logic: a mode change restarts everything and swallows a coincident tick
    always_comb begin
        cnt_d  = cnt_q;
        pos_d  = pos_q;
        dir_d  = dir_q;
        ph_d   = ph_q;
        mode_d = mode_q;
        tick_d = 1'b0;
        if (mode_chg_s) begin
            cnt_d  = {CNT_W{1'b0}};
            pos_d  = {POS_W{1'b0}};
            dir_d  = DIR_UP;
            ph_d   = 1'b1;
            mode_d = mode_e'(mode);
        end else if (tick_s) begin
            cnt_d  = {CNT_W{1'b0}};
            tick_d = 1'b1;
            case (mode_q)
                MODE_CHASE: begin
                    if (pos_q == POS_MAX) begin
                        pos_d = {POS_W{1'b0}};
                    end else begin
                        pos_d = pos_q + POS_W'(1);
                    end
                end
                MODE_BOUNCE: begin
                    // Ends are visited once: turn around by stepping back immediately
                    if (NUM_LEDS == 1) begin
                        pos_d = pos_q;
                    end else if (dir_q == DIR_UP) begin
                        if (pos_q == POS_MAX) begin
                            dir_d = DIR_DOWN;
                            pos_d = pos_q - POS_W'(1);
                        end else begin
                            pos_d = pos_q + POS_W'(1);
                        end
                    end else begin
                        if (pos_q == {POS_W{1'b0}}) begin
                            dir_d = DIR_UP;
                            pos_d = POS_W'(1);
                        end else begin
                            pos_d = pos_q - POS_W'(1);
                        end
                    end
                end
                MODE_BLINK: ph_d = ~ph_q;
                default: begin
                    pos_d = pos_q;
                    ph_d  = ph_q;
                end
            endcase
        end else if (run) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

`ifdef LED_DIM_EN
    logic [3:0] pwm_q;

    // Free-running PWM phase for dimming
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_q <= 4'd0;
        end else begin
            pwm_q <= pwm_q + 4'd1;
        end
    end

    // Output pattern gated by the current PWM phase
    always_comb begin
        pat_s = pattern_f(mode_d, pos_d, ph_d);
        led_d = pat_s & {NUM_LEDS{(pwm_q < duty)}};
    end
`else
    // Output pattern taken straight from the updated state
    always_comb begin
        pat_s = pattern_f(mode_d, pos_d, ph_d);
        led_d = pat_s;
    end
`endif

    // State and registered outputs; mode_q follows the mode pins while in reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= {CNT_W{1'b0}};
            pos_q  <= {POS_W{1'b0}};
            dir_q  <= DIR_UP;
            ph_q   <= 1'b1;
            mode_q <= mode_e'(mode);
            led_q  <= {NUM_LEDS{1'b0}};
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pos_q  <= pos_d;
            dir_q  <= dir_d;
            ph_q   <= ph_d;
            mode_q <= mode_d;
            led_q  <= led_d;
            tick_q <= tick_d;
        end
    end

    assign led       = led_q;
    assign step_tick = tick_q;

endmodule
